uart_tx_byte_feeder: RTL

//  Byte FIFO and send sequencer upstream of the UART byte transmitter. Buffers bytes written by
//  the control/readout logic and hands them one at a time to the transmitter: a one-cycle send

---
 rtl/uart_tx_byte_feeder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_byte_feeder.sv
// Byte FIFO plus send sequencer feeding the UART byte transmitter; one-cycle send pulse per byte,
// waits for tx_done and a programmable idle gap, with a watchdog and sticky overflow/timeout flags.
module uart_tx_byte_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int GAP_CYC = 2,
  parameter int TMO_CYC = 65535
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_err,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          tx_send_en,
  output logic [7:0]    tx_data_byte,
  input  logic          tx_done,
  input  logic          tx_busy,
  output logic          overflow_err,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [15:0]   TMO_LAST = 16'(TMO_CYC - 1);
  localparam logic [15:0]   GAP_LAST = 16'((GAP_CYC == 0) ? 0 : (GAP_CYC - 1));

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_nxt;

  logic [15:0]   tmo_cnt;
  logic [15:0]   gap_cnt;

  logic          push;
  logic          ovf_set;
  logic          done_ok;
  logic          tmo_hit;
  logic          launch;
  logic          tmo_clr;
  logic          tmo_inc;
  logic          tmo_set;
  logic          gap_clr;
  logic          gap_inc;

  // A done pulse coinciding with our own send pulse belongs to the previous frame.
  assign done_ok = tx_done && !tx_send_en;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign launch  = (state == S_IDLE) && !empty && !tx_busy && !flush;

  assign push    = wr_en && !full && !flush;
  assign ovf_set = wr_en &&  full && !flush;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (launch) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_ok) begin
          state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: control strobes ----------------
  always_comb begin
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;
    tmo_set = 1'b0;
    gap_clr = 1'b0;
    gap_inc = 1'b0;
    case (state)
      S_IDLE: begin
        tmo_clr = launch;
      end
      S_WAIT_DONE: begin
        gap_clr = done_ok;
        tmo_inc = !done_ok;
        tmo_set = !done_ok && tmo_hit;
      end
      S_GAP: begin
        gap_inc = 1'b1;
      end
      default: begin
        tmo_clr = 1'b0;
      end
    endcase
  end

  // ---------------- FIFO storage ----------------
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !launch) begin
      count_nxt = count + CNT_ONE;
    end else if (!push && launch) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PTR_ONE;
        if (launch) rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // ---------------- transmitter handshake ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_send_en   <= 1'b0;
      tx_data_byte <= 8'h00;
    end else begin
      tx_send_en <= launch;
      if (launch) tx_data_byte <= mem[rd_ptr];
    end
  end

  // ---------------- watchdog and gap counters ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmo_cnt <= 16'd0;
      gap_cnt <= 16'd0;
    end else begin
      if (tmo_clr) begin
        tmo_cnt <= 16'd0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (gap_clr) begin
        gap_cnt <= 16'd0;
      end else if (gap_inc) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

  // ---------------- sticky errors: a new event beats a same-cycle clear ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      overflow_err <= (overflow_err && !clr_err) || ovf_set;
      timeout_err  <= (timeout_err  && !clr_err) || tmo_set;
    end
  end

endmodule
